// File: rtl/m72_video_pkg.sv
// Shared video-pipeline constants and helpers for the m72 tile/sprite path.
package m72_video_pkg;

  // Default geometry of the tile pixel shifter.
  localparam int DEF_PLANES = 4;
  localparam int DEF_BITS   = 8;
  localparam int DEF_ATTR_W = 8;

  // Widest fetch word any shifter instance may use.
  localparam int MAX_BITS   = 16;

  // Mirror a MAX_BITS-wide word. Narrower words are placed in the upper bits
  // by the caller so the reversed value ends up in the low bits.
  function automatic logic [MAX_BITS-1:0] bitrev(input logic [MAX_BITS-1:0] w);
    logic [MAX_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_BITS; i++) begin
      r[i] = w[MAX_BITS-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/m72_plane_shift.sv
// One bitplane shifter: loads a (possibly mirrored, possibly fine-scrolled)
// fetch word and shifts it out MSB first, one pixel per enabled shift.
module m72_plane_shift
  import m72_video_pkg::*;
#(
  parameter  int BITS = DEF_BITS,
  localparam int SW   = $clog2(BITS)
) (
  input  logic            i_clock,
  input  logic            i_reset_n,
  input  logic            i_clear,
  input  logic            i_load,
  input  logic [BITS-1:0] i_load_word,
  input  logic            i_flip,
  input  logic [SW-1:0]   i_skip,
  input  logic            i_shift_en,
  output logic            o_msb
);

  logic [BITS-1:0] r_sh;
  logic [BITS-1:0] w_oriented;
  logic [BITS-1:0] w_loaded;

  // Mirror on flip, then drop the leading fine-scroll pixels by shifting them out.
  always_comb begin
    w_oriented = i_load_word;
    if (i_flip) begin
      w_oriented = BITS'(bitrev(MAX_BITS'(i_load_word) << (MAX_BITS - BITS)));
    end
    w_loaded = w_oriented << i_skip;
  end

  // Clear wins over load, load wins over shift; shifting fills with zeros.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sh <= '0;
    end else if (i_clear) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= w_loaded;
    end else if (i_shift_en) begin
      r_sh <= {r_sh[BITS-2:0], 1'b0};
    end
  end

  assign o_msb = r_sh[BITS-1];

endmodule

// File: rtl/m72_tile_pixel_shifter.sv
// Tile pixel shifter: serialises PLANES bitplanes into one colour index per
// pixel, with a one-deep fetch buffer, per-fetch H-flip, line-start fine
// scroll, attribute passthrough and underrun detection.
//
// Handshake: a fetch is taken on any clock edge where in_valid and in_ready
// are both high (independent of ce_pixel). in_ready is simply "hold buffer
// empty"; the producer must keep the word and its flip/attr stable while
// in_valid is high and in_ready is low.
module m72_tile_pixel_shifter
  import m72_video_pkg::*;
#(
  parameter  int PLANES = DEF_PLANES,
  parameter  int BITS   = DEF_BITS,
  parameter  int ATTR_W = DEF_ATTR_W,
  localparam int SW     = $clog2(BITS)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   ce_pixel,
  input  logic                   line_start,
  input  logic [SW-1:0]          scroll,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PLANES*BITS-1:0] in_planes,
  input  logic                   in_flip,
  input  logic [ATTR_W-1:0]      in_attr,
  output logic [PLANES-1:0]      pix_color,
  output logic [ATTR_W-1:0]      pix_attr,
  output logic                   pix_valid,
  output logic                   underrun
);

  localparam int            CW       = SW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(BITS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Hold buffer
  logic [PLANES*BITS-1:0] r_hold_planes;
  logic                   r_hold_flip;
  logic [ATTR_W-1:0]      r_hold_attr;
  logic                   r_hold_full;

  // Shifting state
  logic [CW-1:0]          r_cnt;
  logic                   r_skip_pending;
  logic [SW-1:0]          r_scroll;
  logic [ATTR_W-1:0]      r_pix_attr;
  logic                   r_underrun;

  logic                   w_accept;
  logic                   w_xfer;
  logic                   w_shift;
  logic                   w_underrun_evt;
  logic [SW-1:0]          w_skip;
  logic [PLANES-1:0]      w_msb;

  // Control decode: line_start suppresses every pixel-clock action that cycle.
  always_comb begin
    w_accept       = in_valid & ~r_hold_full;
    w_xfer         = ~line_start & ce_pixel & r_hold_full & (r_cnt <= CNT_ONE);
    w_shift        = ~line_start & ce_pixel & (r_cnt != '0) & ~w_xfer;
    w_underrun_evt = ~line_start & ce_pixel & (r_cnt == CNT_ONE) & ~r_hold_full;
    w_skip         = r_skip_pending ? r_scroll : '0;
  end

  // Hold buffer: a same-cycle accept survives a flush or a transfer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold_planes <= '0;
      r_hold_flip   <= 1'b0;
      r_hold_attr   <= '0;
      r_hold_full   <= 1'b0;
    end else if (w_accept) begin
      r_hold_planes <= in_planes;
      r_hold_flip   <= in_flip;
      r_hold_attr   <= in_attr;
      r_hold_full   <= 1'b1;
    end else if (line_start || w_xfer) begin
      r_hold_full   <= 1'b0;
    end
  end

  // Remaining-pixel counter; a transfer reloads it minus the skipped pixels.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (line_start) begin
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_cnt <= CNT_FULL - CW'(w_skip);
    end else if (w_shift) begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  // Fine scroll: latched at line_start, applied once to the next transfer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_skip_pending <= 1'b0;
      r_scroll       <= '0;
    end else if (line_start) begin
      r_skip_pending <= 1'b1;
      r_scroll       <= scroll;
    end else if (w_xfer) begin
      r_skip_pending <= 1'b0;
    end
  end

  // Attribute follows the word that is shifting; underrun is a one-clock pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_attr <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_underrun_evt;
      if (w_xfer) begin
        r_pix_attr <= r_hold_attr;
      end
    end
  end

  for (genvar p = 0; p < PLANES; p++) begin : g_plane
    m72_plane_shift #(
      .BITS (BITS)
    ) u_plane (
      .i_clock     (clock),
      .i_reset_n   (reset_n),
      .i_clear     (line_start),
      .i_load      (w_xfer),
      .i_load_word (r_hold_planes[p*BITS +: BITS]),
      .i_flip      (r_hold_flip),
      .i_skip      (w_skip),
      .i_shift_en  (w_shift),
      .o_msb       (w_msb[p])
    );
  end

  // Outputs are blanked while no pixel is left in the shifters.
  always_comb begin
    pix_valid = (r_cnt != '0);
    pix_color = pix_valid ? w_msb : '0;
    pix_attr  = r_pix_attr;
    underrun  = r_underrun;
    in_ready  = ~r_hold_full;
  end

endmodule

// File: tb/tb_m72_tile_pixel_shifter.sv
// Bench for m72_tile_pixel_shifter: table-driven single-fetch vectors,
// hand-written multi-cycle sequences and randomized traffic, all compared
// against a pixel-queue reference model.
module tb_m72_tile_pixel_shifter;

  localparam int PLANES = 4;
  localparam int BITS   = 8;
  localparam int ATTR_W = 8;
  localparam int SW     = 3;
  localparam int PB     = PLANES * BITS;

  // ---------------- clock / reset / DUT ----------------
  logic              clock = 1'b0;
  logic              reset_n;
  logic              ce_pixel;
  logic              line_start;
  logic [SW-1:0]     scroll;
  logic              in_valid;
  logic              in_ready;
  logic [PB-1:0]     in_planes;
  logic              in_flip;
  logic [ATTR_W-1:0] in_attr;
  logic [PLANES-1:0] pix_color;
  logic [ATTR_W-1:0] pix_attr;
  logic              pix_valid;
  logic              underrun;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  m72_tile_pixel_shifter #(
    .PLANES (PLANES),
    .BITS   (BITS),
    .ATTR_W (ATTR_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .ce_pixel   (ce_pixel),
    .line_start (line_start),
    .scroll     (scroll),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_planes  (in_planes),
    .in_flip    (in_flip),
    .in_attr    (in_attr),
    .pix_color  (pix_color),
    .pix_attr   (pix_attr),
    .pix_valid  (pix_valid),
    .underrun   (underrun)
  );

  // ---------------- reference model ----------------
  // Pixels still to be shown, front = pixel currently on the output.
  logic [PLANES-1:0] m_px[$];
  logic [ATTR_W-1:0] m_attr;
  logic              m_hold_full;
  logic [PB-1:0]     m_hold_planes;
  logic              m_hold_flip;
  logic [ATTR_W-1:0] m_hold_attr;
  logic              m_skip_pending;
  logic [SW-1:0]     m_scroll;
  logic              m_underrun;
  int                m_accepts;

  task automatic model_reset();
    m_px.delete();
    m_attr         = '0;
    m_hold_full    = 1'b0;
    m_hold_planes  = '0;
    m_hold_flip    = 1'b0;
    m_hold_attr    = '0;
    m_skip_pending = 1'b0;
    m_scroll       = '0;
    m_underrun     = 1'b0;
  endtask

  // Colour of pixel k (0 = leftmost on screen) of a fetch word.
  function automatic logic [PLANES-1:0] pixel_of(input logic [PB-1:0] pl, input logic fl, input int k);
    logic [PLANES-1:0] c;
    int b;
    b = fl ? k : BITS - 1 - k;
    for (int p = 0; p < PLANES; p++) c[p] = pl[p*BITS + b];
    return c;
  endfunction

  task automatic model_step(input logic ce, input logic ls, input logic [SW-1:0] sc, input logic v,
                            input logic [PB-1:0] pl, input logic fl, input logic [ATTR_W-1:0] at);
    logic acc;
    logic nu;
    int   s;
    acc = v && !m_hold_full;
    nu  = 1'b0;
    if (ls) begin
      m_px.delete();
      m_hold_full    = 1'b0;
      m_skip_pending = 1'b1;
      m_scroll       = sc;
    end else if (ce) begin
      if (m_px.size() <= 1 && m_hold_full) begin
        s = m_skip_pending ? int'(m_scroll) : 0;
        m_px.delete();
        for (int k = s; k < BITS; k++) m_px.push_back(pixel_of(m_hold_planes, m_hold_flip, k));
        m_attr         = m_hold_attr;
        m_hold_full    = 1'b0;
        m_skip_pending = 1'b0;
      end else if (m_px.size() >= 1) begin
        if (m_px.size() == 1) nu = 1'b1;
        void'(m_px.pop_front());
      end
    end
    if (acc) begin
      m_hold_planes = pl;
      m_hold_flip   = fl;
      m_hold_attr   = at;
      m_hold_full   = 1'b1;
      m_accepts++;
    end
    m_underrun = nu;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [PLANES-1:0] exp_c;
    exp_c = (m_px.size() != 0) ? m_px[0] : '0;
    chk({tag, " pix_valid"}, 32'(pix_valid), 32'(m_px.size() != 0));
    chk({tag, " pix_color"}, 32'(pix_color), 32'(exp_c));
    chk({tag, " pix_attr"},  32'(pix_attr),  32'(m_attr));
    chk({tag, " in_ready"},  32'(in_ready),  32'(!m_hold_full));
    chk({tag, " underrun"},  32'(underrun),  32'(m_underrun));
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; drives, lets one rising edge act, checks at the next falling edge.
  task automatic cycle(input string tag, input logic ce, input logic ls, input logic [SW-1:0] sc,
                       input logic v, input logic [PB-1:0] pl, input logic fl, input logic [ATTR_W-1:0] at);
    ce_pixel   = ce;
    line_start = ls;
    scroll     = sc;
    in_valid   = v;
    in_planes  = pl;
    in_flip    = fl;
    in_attr    = at;
    @(posedge clock);
    model_step(ce, ls, sc, v, pl, fl, at);
    @(negedge clock);
    check_model(tag);
  endtask

  function automatic logic [PB-1:0] word0(input logic [7:0] w);
    return {24'($urandom), w};
  endfunction

  typedef struct {
    logic [7:0]    w;
    logic          fl;
    logic [SW-1:0] sc;
    logic [7:0]    exp;
    int            len;
  } vec_t;

  vec_t tbl[6];

  initial begin : main
    logic [7:0]    e;
    logic [PB-1:0] gw[5];
    int            base;
    int            idx;

    tbl[0] = '{8'hA5, 1'b0, 3'd0, 8'hA5, 8};
    tbl[1] = '{8'hC0, 1'b1, 3'd0, 8'h03, 8};
    tbl[2] = '{8'hC0, 1'b0, 3'd0, 8'hC0, 8};
    tbl[3] = '{8'hB6, 1'b0, 3'd3, 8'hB0, 5};
    tbl[4] = '{8'h81, 1'b1, 3'd7, 8'h80, 1};
    tbl[5] = '{8'h6C, 1'b1, 3'd2, 8'hD8, 6};

    reset_n    = 1'b0;
    ce_pixel   = 1'b0;
    line_start = 1'b0;
    scroll     = '0;
    in_valid   = 1'b0;
    in_planes  = '0;
    in_flip    = 1'b0;
    in_attr    = '0;
    m_accepts  = 0;
    model_reset();
    repeat (2) @(negedge clock);
    check_model("reset");
    chk("reset in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;

    // Reset mid-shift, with a fine scroll armed beforehand.
    cycle("rst_pre", 1'b0, 1'b1, 3'd3, 1'b0, '0, 1'b0, '0);
    cycle("rst_pre", 1'b0, 1'b0, 3'd3, 1'b1, word0(8'h3C), 1'b0, 8'h11);
    repeat (3) cycle("rst_pre", 1'b1, 1'b0, 3'd3, 1'b0, '0, 1'b0, '0);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_model("rst_mid");
    chk("rst_mid pix_color", 32'(pix_color), 32'd0);
    chk("rst_mid in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    e = 8'hA5;
    cycle("rst_a5", 1'b0, 1'b0, 3'd0, 1'b1, word0(e), 1'b0, 8'h22);
    for (int k = 0; k < 8; k++) begin
      cycle("rst_a5", 1'b1, 1'b0, 3'd0, 1'b0, '0, 1'b0, '0);
      chk("rst_a5 px0", 32'(pix_color[0]), 32'(e[7-k]));
    end

    // Table: one fetch per row, flushed and scrolled by line_start.
    for (int r = 0; r < 6; r++) begin
      e = tbl[r].exp;
      cycle("tbl", 1'b0, 1'b1, tbl[r].sc, 1'b0, '0, 1'b0, '0);
      cycle("tbl", 1'b0, 1'b0, 3'd0, 1'b1, word0(tbl[r].w), tbl[r].fl, 8'(r + 1));
      for (int k = 0; k < tbl[r].len; k++) begin
        cycle("tbl", 1'b1, 1'b0, 3'd0, 1'b0, '0, 1'b0, '0);
        chk("tbl px0", 32'(pix_color[0]), 32'(e[7-k]));
        chk("tbl valid", 32'(pix_valid), 32'd1);
      end
      cycle("tbl", 1'b1, 1'b0, 3'd0, 1'b0, '0, 1'b0, '0);
      chk("tbl end valid", 32'(pix_valid), 32'd0);
    end

    // Gapless: producer always offers the next word.
    for (int i = 0; i < 5; i++) gw[i] = PB'($urandom);
    cycle("gap", 1'b0, 1'b1, 3'd0, 1'b0, '0, 1'b0, '0);
    base = m_accepts;
    cycle("gap", 1'b0, 1'b0, 3'd0, 1'b1, gw[0], 1'b0, 8'd1);
    for (int k = 0; k < 24; k++) begin
      idx = m_accepts - base;
      if (idx > 4) idx = 4;
      cycle("gap", 1'b1, 1'b0, 3'd0, 1'b1, gw[idx], 1'b0, 8'(idx + 1));
      chk("gap valid", 32'(pix_valid), 32'd1);
      chk("gap underrun", 32'(underrun), 32'd0);
      chk("gap attr", 32'(pix_attr), 32'(k / 8 + 1));
    end

    // Underrun: second fetch withheld, then arrives late.
    cycle("und", 1'b0, 1'b1, 3'd0, 1'b0, '0, 1'b0, '0);
    cycle("und", 1'b0, 1'b0, 3'd0, 1'b1, word0(8'hFF), 1'b0, 8'h33);
    repeat (8) cycle("und", 1'b1, 1'b0, 3'd0, 1'b0, '0, 1'b0, '0);
    cycle("und", 1'b1, 1'b0, 3'd0, 1'b0, '0, 1'b0, '0);
    chk("und pulse", 32'(underrun), 32'd1);
    chk("und empty", 32'(pix_valid), 32'd0);
    cycle("und", 1'b1, 1'b0, 3'd0, 1'b0, '0, 1'b0, '0);
    chk("und single", 32'(underrun), 32'd0);
    cycle("und", 1'b1, 1'b0, 3'd0, 1'b1, word0(8'h80), 1'b0, 8'h44);
    chk("und late accept", 32'(pix_valid), 32'd0);
    cycle("und", 1'b1, 1'b0, 3'd0, 1'b0, '0, 1'b0, '0);
    chk("und resume valid", 32'(pix_valid), 32'd1);
    chk("und resume px0", 32'(pix_color[0]), 32'd1);

    // Collision: line_start + ce_pixel + in_valid in one clock, mid-shift.
    cycle("col", 1'b0, 1'b1, 3'd0, 1'b0, '0, 1'b0, '0);
    cycle("col", 1'b0, 1'b0, 3'd0, 1'b1, word0(8'hFF), 1'b0, 8'h55);
    repeat (3) cycle("col", 1'b1, 1'b0, 3'd0, 1'b0, '0, 1'b0, '0);
    cycle("col", 1'b1, 1'b1, 3'd2, 1'b1, word0(8'hB6), 1'b0, 8'hAA);
    chk("col flushed", 32'(pix_valid), 32'd0);
    chk("col no underrun", 32'(underrun), 32'd0);
    chk("col held", 32'(in_ready), 32'd0);
    e = 8'hD8;
    for (int k = 0; k < 6; k++) begin
      cycle("col", 1'b1, 1'b0, 3'd5, 1'b0, '0, 1'b0, '0);
      chk("col px0", 32'(pix_color[0]), 32'(e[7-k]));
      chk("col attr", 32'(pix_attr), 32'hAA);
    end
    cycle("col", 1'b1, 1'b0, 3'd5, 1'b0, '0, 1'b0, '0);
    chk("col end valid", 32'(pix_valid), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      cycle("rand",
            1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 49) == 0),
            SW'($urandom),
            1'($urandom_range(0, 9) < 6),
            PB'($urandom),
            1'($urandom_range(0, 1)),
            ATTR_W'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
